// File: rtl/pcie_multich_regfile.sv
// PCIe BAR register file for NUM_TX TX / NUM_RX RX traffic-generator channels.
// Holds channel configuration, per-channel ARP handshake, RX stat snapshots and an ID/scratch page.
module pcie_multich_regfile #(
  parameter int unsigned NUM_TX      = 1,
  parameter int unsigned NUM_RX      = 4,
  parameter int unsigned ARP_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [10:0]             rd_addr,
  output logic [31:0]             rd_data,
  input  logic [10:0]             wr_addr,
  input  logic [7:0]              wr_be,
  input  logic [31:0]             wr_data,
  input  logic                    wr_en,
  output logic                    wr_busy,
  input  logic [31:0]             rom_data,
  output logic [NUM_TX-1:0]       tx_enable,
  output logic [NUM_TX-1:0]       tx_ipv6,
  output logic [NUM_TX-1:0]       tx_req_arp,
  input  logic [NUM_TX-1:0]       tx_arp_ack,
  output logic [16*NUM_TX-1:0]    tx_frame_len,
  output logic [32*NUM_TX-1:0]    tx_ifg,
  output logic [48*NUM_TX-1:0]    tx_src_mac,
  output logic [32*NUM_TX-1:0]    tx_ipv4_srcip,
  output logic [32*NUM_TX-1:0]    tx_ipv4_dstip,
  output logic [128*NUM_TX-1:0]   tx_ipv6_srcip,
  output logic [128*NUM_TX-1:0]   tx_ipv6_dstip,
  input  logic [48*NUM_TX-1:0]    tx_dst_mac,
  input  logic [32*NUM_TX-1:0]    tx_pps,
  input  logic [32*NUM_RX-1:0]    rx_pps,
  input  logic [32*NUM_RX-1:0]    rx_throughput,
  input  logic [24*NUM_RX-1:0]    rx_latency
);

  localparam int unsigned CNT_W   = $clog2(ARP_TIMEOUT);
  localparam logic [31:0] IFG_RST = 32'd1562491;
  localparam logic [31:0] ID_WORD = {8'h02, 8'(NUM_TX), 8'(NUM_RX), 8'h00};

  typedef enum logic {ARP_IDLE = 1'b0, ARP_PEND = 1'b1} arp_state_e;

  // be[0] steers the most-significant byte
  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[31-8*b -: 8] = d[31-8*b -: 8];
    return r;
  endfunction

  logic [NUM_TX-1:0] en_q, ipv6_q, sticky_q, arp_wr;
  logic [15:0]       flen_q   [NUM_TX];
  logic [31:0]       ifg_q    [NUM_TX];
  logic [31:0]       srcip_q  [NUM_TX];
  logic [31:0]       dstip_q  [NUM_TX];
  logic [47:0]       smac_q   [NUM_TX];
  logic [127:0]      v6src_q  [NUM_TX];
  logic [127:0]      v6dst_q  [NUM_TX];
  logic [CNT_W-1:0]  arp_cnt  [NUM_TX];
  arp_state_e        arp_st   [NUM_TX];
  logic [31:0]       thr_q    [NUM_RX];
  logic [23:0]       lat_q    [NUM_RX];
  logic [NUM_RX-1:0] snap_en;
  logic [31:0]       scratch_q, rd_next, rd_q;
  logic              rom_sel_q;
  logic              unused_be;

  assign unused_be = ^wr_be[7:4];
  assign wr_busy   = 1'b0;
  assign rd_data   = rom_sel_q ? rom_data : rd_q;

  // Read decode; RX pps reads also arm that channel's snapshot
  always_comb begin
    rd_next = '0;
    snap_en = '0;
    case (rd_addr[10:8])
      3'b000: begin
        if (rd_addr[7:0] == 8'd0)      rd_next = ID_WORD;
        else if (rd_addr[7:0] == 8'd1) rd_next = scratch_q;
      end
      3'b001: begin
        for (int n = 0; n < NUM_TX; n++) begin
          if (rd_addr[7:5] == 3'(n)) begin
            case (rd_addr[4:0])
              5'h00: rd_next = {en_q[n], ipv6_q[n], 30'b0};
              5'h01: rd_next = {16'b0, flen_q[n]};
              5'h02: rd_next = ifg_q[n];
              5'h03: rd_next = {30'b0, sticky_q[n], arp_st[n] == ARP_PEND};
              5'h04: rd_next = srcip_q[n];
              5'h05: rd_next = {16'b0, smac_q[n][47:32]};
              5'h06: rd_next = smac_q[n][31:0];
              5'h09: rd_next = {16'b0, tx_dst_mac[48*n+32 +: 16]};
              5'h0A: rd_next = tx_dst_mac[48*n +: 32];
              5'h0B: rd_next = dstip_q[n];
              5'h10: rd_next = tx_pps[32*n +: 32];
              5'h18, 5'h19, 5'h1A, 5'h1B: rd_next = v6src_q[n][{~rd_addr[1:0], 5'b0} +: 32];
              5'h1C, 5'h1D, 5'h1E, 5'h1F: rd_next = v6dst_q[n][{~rd_addr[1:0], 5'b0} +: 32];
              default: rd_next = '0;
            endcase
          end
        end
      end
      3'b010: begin
        for (int n = 0; n < NUM_RX; n++) begin
          if (rd_addr[7:2] == 6'(n)) begin
            case (rd_addr[1:0])
              2'd0: begin
                rd_next    = rx_pps[32*n +: 32];
                snap_en[n] = 1'b1;
              end
              2'd1:    rd_next = thr_q[n];
              2'd2:    rd_next = {8'b0, lat_q[n]};
              default: rd_next = '0;
            endcase
          end
        end
      end
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q      <= '0;
      rom_sel_q <= 1'b0;
    end else begin
      rd_q      <= rd_next;
      rom_sel_q <= (rd_addr[10:9] == 2'b11);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_RX; n++) begin
        thr_q[n] <= '0;
        lat_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_RX; n++) begin
        if (snap_en[n]) begin
          thr_q[n] <= rx_throughput[32*n +: 32];
          lat_q[n] <= rx_latency[24*n +: 24];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         scratch_q <= '0;
    else if (wr_en && wr_addr[10:8] == 3'b000 && wr_addr[7:0] == 8'd1)
      scratch_q <= be_merge(scratch_q, wr_data, wr_be[3:0]);
  end

  // TX configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_TX; n++) begin
        en_q[n]    <= 1'b1;
        ipv6_q[n]  <= 1'b0;
        flen_q[n]  <= 16'd64;
        ifg_q[n]   <= IFG_RST;
        smac_q[n]  <= 48'h003776_000100 + 48'(n);
        srcip_q[n] <= {8'd10, 8'd0, 8'(20 + 2*n), 8'd105};
        dstip_q[n] <= {8'd10, 8'd0, 8'(21 + 2*n), 8'd105};
        v6src_q[n] <= {16'h3776, 32'h0, 16'(20 + 2*n), 48'h0, 16'h0105};
        v6dst_q[n] <= {16'h3776, 32'h0, 16'(21 + 2*n), 48'h0, 16'h0105};
      end
    end else if (wr_en && wr_addr[10:8] == 3'b001) begin
      for (int n = 0; n < NUM_TX; n++) begin
        if (wr_addr[7:5] == 3'(n)) begin
          case (wr_addr[4:0])
            5'h00: if (wr_be[0]) begin
              en_q[n]   <= wr_data[31];
              ipv6_q[n] <= wr_data[30];
            end
            5'h01: flen_q[n]  <= 16'(be_merge({16'b0, flen_q[n]}, wr_data, wr_be[3:0]));
            5'h02: ifg_q[n]   <= be_merge(ifg_q[n], wr_data, wr_be[3:0]);
            5'h04: srcip_q[n] <= be_merge(srcip_q[n], wr_data, wr_be[3:0]);
            5'h05: smac_q[n][47:32] <= 16'(be_merge({16'b0, smac_q[n][47:32]}, wr_data, wr_be[3:0]));
            5'h06: smac_q[n][31:0]  <= be_merge(smac_q[n][31:0], wr_data, wr_be[3:0]);
            5'h0B: dstip_q[n] <= be_merge(dstip_q[n], wr_data, wr_be[3:0]);
            5'h18, 5'h19, 5'h1A, 5'h1B:
              v6src_q[n][{~wr_addr[1:0], 5'b0} +: 32] <=
                be_merge(v6src_q[n][{~wr_addr[1:0], 5'b0} +: 32], wr_data, wr_be[3:0]);
            5'h1C, 5'h1D, 5'h1E, 5'h1F:
              v6dst_q[n][{~wr_addr[1:0], 5'b0} +: 32] <=
                be_merge(v6dst_q[n][{~wr_addr[1:0], 5'b0} +: 32], wr_data, wr_be[3:0]);
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    arp_wr = '0;
    if (wr_en && wr_addr[10:8] == 3'b001 && wr_addr[4:0] == 5'h03)
      for (int n = 0; n < NUM_TX; n++) if (wr_addr[7:5] == 3'(n)) arp_wr[n] = 1'b1;
  end

  // ARP handshake: a write (re)starts the wait and beats a same-cycle ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_TX; n++) begin
        arp_st[n]   <= ARP_IDLE;
        arp_cnt[n]  <= '0;
        sticky_q[n] <= 1'b0;
      end
    end else begin
      for (int n = 0; n < NUM_TX; n++) begin
        case (arp_st[n])
          ARP_IDLE: if (arp_wr[n]) begin
            arp_st[n]  <= ARP_PEND;
            arp_cnt[n] <= '0;
          end
          ARP_PEND: begin
            if (arp_wr[n])          arp_cnt[n] <= '0;
            else if (tx_arp_ack[n]) arp_st[n]  <= ARP_IDLE;
            else if (arp_cnt[n] == CNT_W'(ARP_TIMEOUT - 1)) begin
              arp_st[n]   <= ARP_IDLE;
              sticky_q[n] <= 1'b1;
            end else        arp_cnt[n] <= arp_cnt[n] + 1'b1;
          end
          default: arp_st[n] <= ARP_IDLE;
        endcase
        if (arp_wr[n] && wr_data[1]) sticky_q[n] <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_TX; g++) begin : g_out
    assign tx_enable[g]                = en_q[g];
    assign tx_ipv6[g]                  = ipv6_q[g];
    assign tx_req_arp[g]               = (arp_st[g] == ARP_PEND);
    assign tx_frame_len[16*g +: 16]    = flen_q[g];
    assign tx_ifg[32*g +: 32]          = ifg_q[g];
    assign tx_src_mac[48*g +: 48]      = smac_q[g];
    assign tx_ipv4_srcip[32*g +: 32]   = srcip_q[g];
    assign tx_ipv4_dstip[32*g +: 32]   = dstip_q[g];
    assign tx_ipv6_srcip[128*g +: 128] = v6src_q[g];
    assign tx_ipv6_dstip[128*g +: 128] = v6dst_q[g];
  end

endmodule

// File: tb/tb_pcie_multich_regfile.sv
// Directed bench for pcie_multich_regfile with 2 TX / 4 RX channels and a short ARP timeout.
module tb_pcie_multich_regfile;
  localparam int unsigned NTX = 2;
  localparam int unsigned NRX = 4;
  localparam int unsigned TO  = 16;

  logic clk, rst_n;
  logic [10:0] rd_addr, wr_addr;
  logic [31:0] rd_data, wr_data, rom_data;
  logic [7:0]  wr_be;
  logic        wr_en, wr_busy;
  logic [NTX-1:0] tx_enable, tx_ipv6, tx_req_arp, tx_arp_ack;
  logic [16*NTX-1:0]  tx_frame_len;
  logic [32*NTX-1:0]  tx_ifg, tx_ipv4_srcip, tx_ipv4_dstip, tx_pps;
  logic [48*NTX-1:0]  tx_src_mac, tx_dst_mac;
  logic [128*NTX-1:0] tx_ipv6_srcip, tx_ipv6_dstip;
  logic [32*NRX-1:0]  rx_pps, rx_throughput;
  logic [24*NRX-1:0]  rx_latency;

  int passed = 0;
  int total  = 0;
  logic [31:0] rv;
  int cyc;

  pcie_multich_regfile #(.NUM_TX(NTX), .NUM_RX(NRX), .ARP_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_en(wr_en), .wr_busy(wr_busy),
    .rom_data(rom_data), .tx_enable(tx_enable), .tx_ipv6(tx_ipv6), .tx_req_arp(tx_req_arp),
    .tx_arp_ack(tx_arp_ack), .tx_frame_len(tx_frame_len), .tx_ifg(tx_ifg),
    .tx_src_mac(tx_src_mac), .tx_ipv4_srcip(tx_ipv4_srcip), .tx_ipv4_dstip(tx_ipv4_dstip),
    .tx_ipv6_srcip(tx_ipv6_srcip), .tx_ipv6_dstip(tx_ipv6_dstip), .tx_dst_mac(tx_dst_mac),
    .tx_pps(tx_pps), .rx_pps(rx_pps), .rx_throughput(rx_throughput), .rx_latency(rx_latency)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic rd(input logic [10:0] a, output logic [31:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
    rd_addr = 11'h0FF;
  endtask

  task automatic wr(input logic [10:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    wr_addr = a; wr_be = {4'b0, be}; wr_data = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Count consecutive sampled cycles with tx_req_arp[0] high, bounded
  task automatic count_req(output int n);
    n = 0;
    while (tx_req_arp[0] && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    rd_addr = 11'h0FF; wr_addr = '0; wr_be = '0; wr_data = '0; wr_en = 1'b0;
    rom_data = 32'hDEADBEEF; tx_arp_ack = '0;
    tx_dst_mac = {48'h0, 48'hA1B2_C3D4_E5F6};
    tx_pps = {32'h0, 32'h0000_0777};
    rx_pps = '0; rx_throughput = '0; rx_latency = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_req_arp", 32'(tx_req_arp), 32'h0);
    chk("rst_enable", 32'(tx_enable), 32'h3);
    chk("rst_frame_len", tx_frame_len, {16'd64, 16'd64});
    chk("rst_ifg0", tx_ifg[31:0], 32'h0017D77B);
    chk("rst_mac1_low", tx_src_mac[79:48], 32'h7600_0101);
    chk("rst_dstip0", tx_ipv4_dstip[31:0], 32'h0A00_1569);
    rst_n = 1'b1;

    rd(11'h000, rv); chk("id", rv, 32'h0202_0400);
    rd(11'h101, rv); chk("tx0_flen", rv, 32'h0000_0040);
    rd(11'h102, rv); chk("tx0_ifg", rv, 32'h0017_D77B);
    rd(11'h205, rv); chk("rx1_snap_rst", rv, 32'h0);

    // byte enable [3] hits bits 7:0 only
    wr(11'h124, 4'b1000, 32'h0000_00AA);
    chk("tx1_srcip_port", tx_ipv4_srcip[63:32], 32'h0A00_16AA);
    chk("tx0_srcip_port", tx_ipv4_srcip[31:0], 32'h0A00_1469);
    rd(11'h124, rv); chk("tx1_srcip_rd", rv, 32'h0A00_16AA);
    wr(11'h101, 4'b0100, 32'h0000_1234);
    rd(11'h101, rv); chk("tx0_flen_be", rv, 32'h0000_1240);
    wr(11'h120, 4'b0001, 32'h4000_0000);
    chk("tx_enable_ctrl", 32'(tx_enable), 32'h1);
    chk("tx_ipv6_ctrl", 32'(tx_ipv6), 32'h2);
    rd(11'h120, rv); chk("tx1_ctrl_rd", rv, 32'h4000_0000);
    wr(11'h109, 4'hF, 32'hFFFF_FFFF);
    rd(11'h109, rv); chk("tx0_dmac_hi", rv, 32'h0000_A1B2);
    rd(11'h10A, rv); chk("tx0_dmac_lo", rv, 32'hC3D4_E5F6);
    rd(11'h110, rv); chk("tx0_pps", rv, 32'h0000_0777);
    rd(11'h118, rv); chk("tx0_v6src_w0", rv, 32'h3776_0000);

    // ARP timeout
    wr(11'h103, 4'hF, 32'h0);
    count_req(cyc);
    chk("arp_timeout_len", 32'(cyc), TO);
    rd(11'h103, rv); chk("arp_sticky", rv, 32'h2);

    // ARP ack; data bit1 clears sticky
    wr(11'h103, 4'hF, 32'h2);
    repeat (4) @(negedge clk);
    chk("arp_pend_before_ack", 32'(tx_req_arp), 32'h1);
    tx_arp_ack = 2'b01;
    @(negedge clk);
    tx_arp_ack = 2'b00;
    chk("arp_ack_low", 32'(tx_req_arp), 32'h0);
    rd(11'h103, rv); chk("arp_ack_status", rv, 32'h0);

    // ack and write together: write wins, counter restarts
    wr(11'h103, 4'hF, 32'h0);
    repeat (9) @(negedge clk);
    wr_addr = 11'h103; wr_be = 8'h0F; wr_data = 32'h0; wr_en = 1'b1; tx_arp_ack = 2'b01;
    @(negedge clk);
    wr_en = 1'b0; tx_arp_ack = 2'b00;
    count_req(cyc);
    chk("arp_restart_len", 32'(cyc), TO);

    // RX snapshot coherence on channel 2
    rx_pps[95:64] = 32'h0000_0055;
    rx_throughput[95:64] = 32'h1111_1111;
    rx_latency[71:48] = 24'hABCDEF;
    rd(11'h208, rv); chk("rx2_pps", rv, 32'h0000_0055);
    rx_throughput[95:64] = 32'h2222_2222;
    rx_latency[71:48] = 24'h123456;
    rd(11'h209, rv); chk("rx2_thr_old", rv, 32'h1111_1111);
    rd(11'h20A, rv); chk("rx2_lat_old", rv, 32'h00AB_CDEF);
    rd(11'h20B, rv); chk("rx2_off3", rv, 32'h0);
    rd(11'h208, rv); chk("rx2_pps_again", rv, 32'h0000_0055);
    rd(11'h209, rv); chk("rx2_thr_new", rv, 32'h2222_2222);

    rd(11'h600, rv); chk("rom", rv, 32'hDEAD_BEEF);
    wr(11'h140, 4'hF, 32'h0);
    rd(11'h140, rv); chk("tx_oob_rd", rv, 32'h0);
    rd(11'h300, rv); chk("unmapped_rd", rv, 32'h0);

    wr(11'h000, 4'hF, 32'h1234_5678);
    rd(11'h000, rv); chk("id_ro", rv, 32'h0202_0400);
    wr(11'h001, 4'hF, 32'hCAFE_F00D);
    rd(11'h001, rv); chk("scratch", rv, 32'hCAFE_F00D);

    // same-cycle read and write of scratch
    @(negedge clk);
    rd_addr = 11'h001;
    wr_addr = 11'h001; wr_be = 8'h0F; wr_data = 32'h1234_5678; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    chk("rw_same_old", rd_data, 32'hCAFE_F00D);
    @(negedge clk);
    chk("rw_same_new", rd_data, 32'h1234_5678);
    rd_addr = 11'h0FF;

    // async reset during a pending ARP
    wr(11'h103, 4'hF, 32'h0);
    chk("arp_pend_pre_rst", 32'(tx_req_arp), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arp_async_rst", 32'(tx_req_arp), 32'h0);
    chk("enable_async_rst", 32'(tx_enable), 32'h3);
    @(negedge clk);
    rst_n = 1'b1;
    rd(11'h001, rv); chk("scratch_after_rst", rv, 32'h0);
    rd(11'h101, rv); chk("flen_after_rst", rv, 32'h0000_0040);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
